batt_monitor: RTL and testbench

BATT_MONITOR -- requirements
Module: batt_monitor

---
 rtl/batt_monitor_pkg.sv | 25 ++
 rtl/bm_debounce.sv | 48 ++++
 rtl/batt_monitor.sv | 154 +++++++++++++++
 tb/tb_batt_monitor.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/batt_monitor_pkg.sv
// Shared types and default thresholds for the battery monitor.
package batt_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_V,
    WAIT_V,
    REQ_I,
    WAIT_I
  } state_e;

  localparam logic CH_VBAT = 1'b0;
  localparam logic CH_IBAT = 1'b1;

  localparam int DEF_W         = 10;
  localparam int DEF_VTRKL_TH  = 300;
  localparam int DEF_VTERM_TH  = 840;
  localparam int DEF_VRCHRG_TH = 800;
  localparam int DEF_ITERM_TH  = 20;
  localparam int DEF_HYST      = 8;
  localparam int DEF_DEB       = 3;
  localparam int DEF_PERIOD    = 64;
  localparam int DEF_TMO       = 32;

endpackage

// File: rtl/bm_debounce.sv
// One hysteresis flag: toggles after DEB consecutive samples meeting the
// opposite-state condition; any other sample restarts the count.
module bm_debounce #(
  parameter int DEB = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_i,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o
);

  localparam int CW = (DEB > 1) ? $clog2(DEB + 1) : 1;

  logic          flag_q, flag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          toward;

  always_comb begin
    flag_d = flag_q;
    cnt_d  = cnt_q;
    toward = flag_q ? clr_i : set_i;
    if (sample_i) begin
      if (!toward) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEB - 1)) begin
        flag_d = ~flag_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/batt_monitor.sv
// Periodic VBAT/IBAT conversion sequencer with debounced hysteresis flags
// and a sticky ADC timeout error.
module batt_monitor
  import batt_monitor_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int VTRKL_TH  = DEF_VTRKL_TH,
  parameter int VTERM_TH  = DEF_VTERM_TH,
  parameter int VRCHRG_TH = DEF_VRCHRG_TH,
  parameter int ITERM_TH  = DEF_ITERM_TH,
  parameter int HYST      = DEF_HYST,
  parameter int DEB       = DEF_DEB,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int TMO       = DEF_TMO
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic         conv_start,
  output logic         conv_ch,
  input  logic         conv_done,
  input  logic [W-1:0] conv_data,
  output logic         vtrkl,
  output logic         vterm,
  output logic         iterm,
  output logic         vrchrg,
  output logic         adc_err
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = $clog2(TMO + 1);

  // Thresholds +/- hysteresis at W+1 bits, saturated into the ADC code range
  localparam logic [W:0] MAXV      = {1'b0, {W{1'b1}}};
  localparam logic [W:0] HYST_X    = (W+1)'(HYST);
  localparam logic [W:0] VTRKL_X   = (W+1)'(VTRKL_TH);
  localparam logic [W:0] VTERM_X   = (W+1)'(VTERM_TH);
  localparam logic [W:0] VRCHRG_X  = (W+1)'(VRCHRG_TH);
  localparam logic [W:0] ITERM_X   = (W+1)'(ITERM_TH);
  localparam logic [W:0] VTRKL_LO  = (VTRKL_X >= HYST_X) ? VTRKL_X - HYST_X : '0;
  localparam logic [W:0] VTERM_LO  = (VTERM_X >= HYST_X) ? VTERM_X - HYST_X : '0;
  localparam logic [W:0] VRCHRG_HS = VRCHRG_X + HYST_X;
  localparam logic [W:0] ITERM_HS  = ITERM_X + HYST_X;
  localparam logic [W:0] VRCHRG_HI = (VRCHRG_HS > MAXV) ? MAXV : VRCHRG_HS;
  localparam logic [W:0] ITERM_HI  = (ITERM_HS > MAXV) ? MAXV : ITERM_HS;

  state_e        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  logic [W:0]    d_ext;
  logic          v_smp, i_smp;

  assign per_d = (per_q == PW'(PERIOD - 1)) ? '0 : per_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE:   if (en && (per_q == '0)) state_d = REQ_V;
      REQ_V: begin
        state_d = WAIT_V;
        tmo_d   = '0;
      end
      WAIT_V: begin
        if (conv_done) begin
          state_d = REQ_I;
        end else if (tmo_q == TW'(TMO - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      REQ_I: begin
        state_d = WAIT_I;
        tmo_d   = '0;
      end
      WAIT_I: begin
        if (conv_done) begin
          state_d = IDLE;
        end else if (tmo_q == TW'(TMO - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      per_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign conv_start = (state_q == REQ_V) || (state_q == REQ_I);
  assign conv_ch    = ((state_q == REQ_I) || (state_q == WAIT_I)) ? CH_IBAT : CH_VBAT;
  assign adc_err    = err_q;

  // Results are only accepted in the matching WAIT state
  assign d_ext = {1'b0, conv_data};
  assign v_smp = (state_q == WAIT_V) && conv_done;
  assign i_smp = (state_q == WAIT_I) && conv_done;

  bm_debounce #(.DEB(DEB)) u_vtrkl (
    .clk      (clk),
    .rst_n    (reset_n),
    .sample_i (v_smp),
    .set_i    (d_ext >= VTRKL_X),
    .clr_i    (d_ext < VTRKL_LO),
    .flag_o   (vtrkl)
  );

  bm_debounce #(.DEB(DEB)) u_vterm (
    .clk      (clk),
    .rst_n    (reset_n),
    .sample_i (v_smp),
    .set_i    (d_ext >= VTERM_X),
    .clr_i    (d_ext < VTERM_LO),
    .flag_o   (vterm)
  );

  bm_debounce #(.DEB(DEB)) u_vrchrg (
    .clk      (clk),
    .rst_n    (reset_n),
    .sample_i (v_smp),
    .set_i    (d_ext < VRCHRG_X),
    .clr_i    (d_ext >= VRCHRG_HI),
    .flag_o   (vrchrg)
  );

  bm_debounce #(.DEB(DEB)) u_iterm (
    .clk      (clk),
    .rst_n    (reset_n),
    .sample_i (i_smp),
    .set_i    (d_ext <= ITERM_X),
    .clr_i    (d_ext > ITERM_HI),
    .flag_o   (iterm)
  );

endmodule

// File: tb/tb_batt_monitor.sv
// Scenario bench for batt_monitor against a sequence-level reference model.
module tb_batt_monitor;

  localparam int W         = 10;
  localparam int VTRKL_TH  = 300;
  localparam int VTERM_TH  = 840;
  localparam int VRCHRG_TH = 800;
  localparam int ITERM_TH  = 20;
  localparam int HYST      = 8;
  localparam int DEB       = 3;
  localparam int PERIOD    = 64;
  localparam int TMO       = 32;
  localparam int MAXC      = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic         conv_start;
  logic         conv_ch;
  logic         conv_done;
  logic [W-1:0] conv_data;
  logic         vtrkl, vterm, iterm, vrchrg, adc_err;

  int vectors = 0;
  int miscompares = 0;

  // Model state: flag index 0=vtrkl 1=vterm 2=vrchrg 3=iterm
  bit [3:0] mflag;
  int       mcnt [4];
  bit       merr;

  always #5 clk = ~clk;

  batt_monitor #(
    .W(W), .VTRKL_TH(VTRKL_TH), .VTERM_TH(VTERM_TH), .VRCHRG_TH(VRCHRG_TH),
    .ITERM_TH(ITERM_TH), .HYST(HYST), .DEB(DEB), .PERIOD(PERIOD), .TMO(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .conv_start(conv_start), .conv_ch(conv_ch),
    .conv_done(conv_done), .conv_data(conv_data),
    .vtrkl(vtrkl), .vterm(vterm), .iterm(iterm), .vrchrg(vrchrg),
    .adc_err(adc_err)
  );

  function automatic int sub_sat(int a, int b);
    return (a - b < 0) ? 0 : a - b;
  endfunction

  function automatic int add_sat(int a, int b);
    return (a + b > MAXC) ? MAXC : a + b;
  endfunction

  function automatic void model_reset();
    mflag = '0;
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
    merr = 1'b0;
  endfunction

  // A flag flips once DEB samples in a row pull it the other way
  function automatic void model_sample(int k, bit set_met, bit clr_met);
    bit pull;
    pull = mflag[k] ? clr_met : set_met;
    if (!pull) mcnt[k] = 0;
    else begin
      mcnt[k]++;
      if (mcnt[k] == DEB) begin
        mflag[k] = ~mflag[k];
        mcnt[k]  = 0;
      end
    end
  endfunction

  function automatic void model_v(int v);
    model_sample(0, v >= VTRKL_TH, v < sub_sat(VTRKL_TH, HYST));
    model_sample(1, v >= VTERM_TH, v < sub_sat(VTERM_TH, HYST));
    model_sample(2, v < VRCHRG_TH, v >= add_sat(VRCHRG_TH, HYST));
  endfunction

  function automatic void model_i(int i);
    model_sample(3, i <= ITERM_TH, i > add_sat(ITERM_TH, HYST));
  endfunction

  function automatic logic dut_flag(int k);
    case (k)
      0:       return vtrkl;
      1:       return vterm;
      2:       return vrchrg;
      default: return iterm;
    endcase
  endfunction

  function automatic string fname(int k);
    case (k)
      0:       return "vtrkl";
      1:       return "vterm";
      2:       return "vrchrg";
      default: return "iterm";
    endcase
  endfunction

  task automatic wait_start(output bit seen);
    int n;
    n = 0;
    while (conv_start !== 1'b1 && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    seen = (conv_start === 1'b1);
  endtask

  // One full V/I sequence; glitch holds conv_done high with junk data during
  // each conv_start cycle, which the DUT must ignore.
  task automatic do_sequence(input int v, input int i, input int dv, input int di,
                             input bit glitch, input bit drop_en);
    bit seen;
    wait_start(seen);
    vectors++;
    if (!seen || conv_ch !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_start_v: seen=%0b ch=%0b required seen=1 ch=0", seen, conv_ch);
    end
    conv_done = glitch;
    conv_data = W'($urandom_range(0, MAXC));
    for (int k = 1; k <= dv; k++) begin
      @(negedge clk);
      conv_done = (k == dv);
      conv_data = W'(v);
    end
    vectors++;
    if (conv_ch !== 1'b0) begin
      miscompares++;
      $display("FAIL ch_hold_v: got %0b required 0", conv_ch);
    end
    @(negedge clk);
    model_v(v);
    vectors++;
    if (conv_start !== 1'b1 || conv_ch !== 1'b1) begin
      miscompares++;
      $display("FAIL seq_start_i: start=%0b ch=%0b required 1 1", conv_start, conv_ch);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (dut_flag(k) !== mflag[k]) begin
        miscompares++;
        $display("FAIL %s_after_v (v=%0d): got %0b required %0b", fname(k), v, dut_flag(k), mflag[k]);
      end
    end
    if (drop_en) en = 1'b0;
    conv_done = glitch;
    conv_data = W'($urandom_range(0, MAXC));
    for (int k = 1; k <= di; k++) begin
      @(negedge clk);
      conv_done = (k == di);
      conv_data = W'(i);
    end
    vectors++;
    if (conv_ch !== 1'b1) begin
      miscompares++;
      $display("FAIL ch_hold_i: got %0b required 1", conv_ch);
    end
    @(negedge clk);
    conv_done = 1'b0;
    model_i(i);
    vectors++;
    if (conv_start !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_end_idle: conv_start=%0b required 0", conv_start);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (dut_flag(k) !== mflag[k]) begin
        miscompares++;
        $display("FAIL %s_after_seq (v=%0d i=%0d): got %0b required %0b", fname(k), v, i, dut_flag(k), mflag[k]);
      end
    end
    vectors++;
    if (adc_err !== merr) begin
      miscompares++;
      $display("FAIL adc_err_after_seq: got %0b required %0b", adc_err, merr);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    en        = 1'b0;
    conv_done = 1'b0;
    conv_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({conv_start, conv_ch, vtrkl, vterm, iterm, vrchrg, adc_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {conv_start, conv_ch, vtrkl, vterm, iterm, vrchrg, adc_err});
    end
    en      = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (conv_start !== 1'b1 || conv_ch !== 1'b0) begin
      miscompares++;
      $display("FAIL first_start_cycle1: start=%0b ch=%0b required 1 0", conv_start, conv_ch);
    end
  endtask

  task automatic test_trickle();
    for (int n = 0; n < 3; n++) begin
      do_sequence(310, 100, 5, 5, 1'b0, 1'b0);
      vectors++;
      if (vtrkl !== (n == 2)) begin
        miscompares++;
        $display("FAIL trickle_seq%0d: vtrkl=%0b required %0b", n + 1, vtrkl, (n == 2));
      end
    end
  endtask

  task automatic test_hysteresis();
    for (int n = 0; n < 5; n++) do_sequence(295, 100, 3, 4, 1'b0, 1'b0);
    vectors++;
    if (vtrkl !== 1'b1) begin
      miscompares++;
      $display("FAIL hyst_band_hold: vtrkl=%0b required 1", vtrkl);
    end
    for (int n = 0; n < 3; n++) do_sequence(291, 100, 2, 2, 1'b0, 1'b0);
    vectors++;
    if (vtrkl !== 1'b0) begin
      miscompares++;
      $display("FAIL hyst_clear: vtrkl=%0b required 0", vtrkl);
    end
  endtask

  task automatic test_vterm_alternating();
    for (int n = 0; n < 8; n++) do_sequence((n % 2 == 0) ? 845 : 835, 100, 1, 1, 1'b1, 1'b0);
    vectors++;
    if (vterm !== 1'b0) begin
      miscompares++;
      $display("FAIL vterm_alternating: vterm=%0b required 0", vterm);
    end
  endtask

  task automatic test_termination();
    for (int n = 0; n < 3; n++) do_sequence(840, 18, 4, 6, 1'b0, 1'b0);
    vectors++;
    if (iterm !== 1'b1 || vterm !== 1'b1) begin
      miscompares++;
      $display("FAIL term_flags: iterm=%0b vterm=%0b required 1 1", iterm, vterm);
    end
    for (int n = 0; n < 3; n++) do_sequence(790, 18, 4, 6, 1'b0, 1'b0);
    vectors++;
    if (vrchrg !== 1'b1) begin
      miscompares++;
      $display("FAIL recharge_flag: vrchrg=%0b required 1", vrchrg);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    wait_start(seen);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL timeout_start: conv_start not seen, required 1");
    end
    repeat (TMO) @(negedge clk);
    vectors++;
    if (adc_err !== merr) begin
      miscompares++;
      $display("FAIL timeout_early: adc_err=%0b required %0b", adc_err, merr);
    end
    @(negedge clk);
    merr = 1'b1;
    vectors++;
    if (adc_err !== 1'b1 || conv_start !== 1'b0 || conv_ch !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err: err=%0b start=%0b ch=%0b required 1 0 0", adc_err, conv_start, conv_ch);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (dut_flag(k) !== mflag[k]) begin
        miscompares++;
        $display("FAIL %s_timeout_hold: got %0b required %0b", fname(k), dut_flag(k), mflag[k]);
      end
    end
    do_sequence(500, 40, 3, 3, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int v, i;
    int bases [3] = '{VTRKL_TH, VTERM_TH, VRCHRG_TH};
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, MAXC);
      else v = bases[$urandom_range(0, 2)] + $urandom_range(0, 30) - 15;
      i = $urandom_range(0, 40);
      do_sequence(v, i, $urandom_range(1, 20), $urandom_range(1, 20),
                  1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_en_drop();
    int starts;
    do_sequence(850, 10, 3, 8, 1'b0, 1'b1);
    starts = 0;
    repeat (3 * PERIOD) begin
      @(negedge clk);
      if (conv_start === 1'b1) starts++;
    end
    vectors++;
    if (starts != 0) begin
      miscompares++;
      $display("FAIL en_low_starts: got %0d conv_start cycles required 0", starts);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (dut_flag(k) !== mflag[k]) begin
        miscompares++;
        $display("FAIL %s_en_low_hold: got %0b required %0b", fname(k), dut_flag(k), mflag[k]);
      end
    end
    en = 1'b1;
    do_sequence(850, 10, 2, 2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    wait_start(seen);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({conv_start, conv_ch, vtrkl, vterm, iterm, vrchrg, adc_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL async_reset_mid: got %b required 0000000",
               {conv_start, conv_ch, vtrkl, vterm, iterm, vrchrg, adc_err});
    end
    @(negedge clk);
    conv_done = 1'b1;
    conv_data = W'(900);
    reset_n   = 1'b1;
    @(negedge clk);
    do_sequence(320, 25, 2, 3, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++) do_sequence(320, 25, 2, 3, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_trickle();
    test_hysteresis();
    test_vterm_alternating();
    test_termination();
    test_timeout();
    test_random();
    test_en_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
